// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg
// Shared definitions for the clock-waveform scheduler.
//   state_t      : scheduler FSM states (2-bit encoding)
//   DEF_CNT_W    : default width of phase-length config and phase counter
//   DEF_BURST_W  : default width of burst length and period counter
package clk_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int DEF_CNT_W   = 8;
   localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/clk_sched_cfg_shadow.sv
// clk_sched_cfg_shadow
// Holds the shadow (written) and active (in use) phase-length configuration.
// A write always lands in the shadow. The active copy only changes on an
// apply strobe from the FSM, so a running period never sees a half-changed
// configuration.
// Ports:
//   clk, rst           : system clock, asynchronous active-low reset
//   cfg_wr             : one-cycle write pulse for cfg_high/cfg_low
//   cfg_high, cfg_low  : phase lengths minus 1
//   apply              : FSM strobe, copy a pending shadow into the active copy
//   act_high, act_low  : active phase lengths minus 1
//   cfg_pending        : shadow holds a value not yet made active
module clk_sched_cfg_shadow
   import clk_sched_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_low,
   input  logic             apply,
   output logic [CNT_W-1:0] act_high,
   output logic [CNT_W-1:0] act_low,
   output logic             cfg_pending
);

   logic [CNT_W-1:0] sh_high;
   logic [CNT_W-1:0] sh_low;

   // On an apply edge the previous shadow moves to active first. A write on
   // the same edge then refills the shadow and keeps cfg_pending set, so the
   // newer value waits for the following boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_high     <= '0;
         sh_low      <= '0;
         act_high    <= '0;
         act_low     <= '0;
         cfg_pending <= 1'b0;
      end else begin
         if (apply && cfg_pending) begin
            act_high <= sh_high;
            act_low  <= sh_low;
         end
         if (cfg_wr) begin
            sh_high     <= cfg_high;
            sh_low      <= cfg_low;
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_sched_ctrl.sv
// clk_sched_ctrl
// Programmable clock-waveform scheduler. Produces a registered divided clock
// with independently set high/low phase lengths. It runs either free-running
// or for a burst of N periods, and supports a graceful stop that always
// finishes the current period.
// Ports:
//   clk, rst           : system clock, asynchronous active-low reset
//   cfg_wr             : write cfg_high/cfg_low into the shadow config
//   cfg_high, cfg_low  : high/low phase length minus 1, in clk cycles
//   start              : begin generation (honoured in IDLE only)
//   burst_len          : periods to emit, sampled with start; 0 = free-run
//   stop               : request a graceful stop
//   clk_out            : generated clock (registered)
//   rise               : pulse in the first high cycle of each period
//   done               : pulse on return to IDLE after generation
//   busy               : generator active
//   cfg_pending        : shadow config not yet applied
module clk_sched_ctrl
   import clk_sched_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_wr,
   input  logic [CNT_W-1:0]   cfg_high,
   input  logic [CNT_W-1:0]   cfg_low,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               stop,
   output logic               clk_out,
   output logic               rise,
   output logic               done,
   output logic               busy,
   output logic               cfg_pending
);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [BURST_W-1:0] per_cnt, per_n, per_inc;
   logic [BURST_W-1:0] burst_q, burst_n;
   logic               stop_req, stop_n;
   logic               clk_out_n, rise_n, done_n;
   logic               apply;
   logic [CNT_W-1:0]   act_high, act_low;

   clk_sched_cfg_shadow #(
      .CNT_W (CNT_W)
   ) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr      (cfg_wr),
      .cfg_high    (cfg_high),
      .cfg_low     (cfg_low),
      .apply       (apply),
      .act_high    (act_high),
      .act_low     (act_low),
      .cfg_pending (cfg_pending)
   );

   assign per_inc = per_cnt + 1'b1;

   // Next-state logic. All outputs are registered, so this block computes
   // their values for the cycle after the coming edge. The shadow is applied
   // on every IDLE edge, which also covers the start edge. It is applied
   // again on each LOW->HIGH boundary so a period always uses one frozen
   // configuration. A stop seen in the final LOW cycle still counts, because
   // the period is complete at that edge anyway.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      per_n     = per_cnt;
      burst_n   = burst_q;
      stop_n    = stop_req | stop;
      clk_out_n = 1'b0;
      rise_n    = 1'b0;
      done_n    = 1'b0;
      apply     = 1'b0;
      case (state)
         IDLE: begin
            apply  = 1'b1;
            stop_n = 1'b0;
            if (start && !stop) begin
               state_n   = HIGH;
               cnt_n     = '0;
               per_n     = '0;
               burst_n   = burst_len;
               clk_out_n = 1'b1;
               rise_n    = 1'b1;
            end
         end
         HIGH: begin
            clk_out_n = 1'b1;
            if (cnt == act_high) begin
               state_n   = LOW;
               cnt_n     = '0;
               clk_out_n = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         LOW: begin
            if (cnt == act_low) begin
               cnt_n = '0;
               per_n = per_inc;
               if (stop_n || ((burst_q != '0) && (per_inc == burst_q))) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  stop_n  = 1'b0;
               end else begin
                  state_n   = HIGH;
                  clk_out_n = 1'b1;
                  rise_n    = 1'b1;
                  apply     = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            stop_n  = 1'b0;
         end
      endcase
   end

   // State, counter and output registers. busy is registered alongside the
   // state so that it always tracks the state exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         per_cnt  <= '0;
         burst_q  <= '0;
         stop_req <= 1'b0;
         clk_out  <= 1'b0;
         rise     <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         per_cnt  <= per_n;
         burst_q  <= burst_n;
         stop_req <= stop_n;
         clk_out  <= clk_out_n;
         rise     <= rise_n;
         done     <= done_n;
         busy     <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// tb_clk_sched_ctrl
// Self-checking bench for clk_sched_ctrl. A period-position model predicts
// every output on every cycle. Directed scenarios add hand-computed literal
// expectations (pulse counts, pending flags, async reset).
module tb_clk_sched_ctrl;

   logic       clk;
   logic       rst;
   logic       cfg_wr;
   logic [7:0] cfg_high;
   logic [7:0] cfg_low;
   logic       start;
   logic [7:0] burst_len;
   logic       stop;
   logic       clk_out;
   logic       rise;
   logic       done;
   logic       busy;
   logic       cfg_pending;

   int n_cmp  = 0;
   int n_fail = 0;

   clk_sched_ctrl #(
      .CNT_W   (8),
      .BURST_W (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr      (cfg_wr),
      .cfg_high    (cfg_high),
      .cfg_low     (cfg_low),
      .start       (start),
      .burst_len   (burst_len),
      .stop        (stop),
      .clk_out     (clk_out),
      .rise        (rise),
      .done        (done),
      .busy        (busy),
      .cfg_pending (cfg_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the running waveform is described by the position
   // within the current period (0 .. hi+lo+1). The output is high while the
   // position is at most hi, and rise marks position 0.
   bit         m_run;
   int         m_pos;
   int         m_hi, m_lo, m_sh_hi, m_sh_lo;
   bit         m_pend;
   logic [7:0] m_per;
   logic [7:0] m_burst;
   bit         m_stopreq;
   bit         m_done;
   bit         adv_apply;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run = 0; m_pos = 0; m_hi = 0; m_lo = 0; m_sh_hi = 0; m_sh_lo = 0;
         m_pend = 0; m_per = 0; m_burst = 0; m_stopreq = 0; m_done = 0;
      end else begin
         m_done    = 0;
         adv_apply = 0;
         if (!m_run) begin
            adv_apply = 1;
            m_stopreq = 0;
            if (start && !stop) begin
               m_run = 1; m_pos = 0; m_per = 0; m_burst = burst_len;
            end
         end else begin
            if (stop) m_stopreq = 1;
            if (m_pos == m_hi + m_lo + 1) begin
               m_per = m_per + 8'd1;
               m_pos = 0;
               if (m_stopreq || (m_burst != 0 && m_per == m_burst)) begin
                  m_run = 0; m_done = 1; m_stopreq = 0;
               end else begin
                  adv_apply = 1;
               end
            end else begin
               m_pos++;
            end
         end
         if (adv_apply && m_pend) begin
            m_hi = m_sh_hi; m_lo = m_sh_lo; m_pend = 0;
         end
         if (cfg_wr) begin
            m_sh_hi = int'(cfg_high); m_sh_lo = int'(cfg_low); m_pend = 1;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("model_clk_out", int'(clk_out), int'(m_run && (m_pos <= m_hi)));
      checkOutput("model_rise", int'(rise), int'(m_run && (m_pos == 0)));
      checkOutput("model_done", int'(done), int'(m_done));
      checkOutput("model_busy", int'(busy), int'(m_run));
      checkOutput("model_cfg_pending", int'(cfg_pending), int'(m_pend));
   end

   // Drives one set of inputs for exactly one active edge. It is called at a
   // negedge and returns at the following negedge with the pulses cleared.
   task automatic applyStimulus(input logic w, input logic [7:0] h, input logic [7:0] l,
                                input logic s, input logic [7:0] b, input logic p);
      cfg_wr    = w;
      cfg_high  = h;
      cfg_low   = l;
      start     = s;
      burst_len = b;
      stop      = p;
      @(negedge clk);
      cfg_wr = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
   endtask

   task automatic runCycles(input int n, output int highs, output int rises, output int dones);
      highs = 0; rises = 0; dones = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         highs += int'(clk_out);
         rises += int'(rise);
         dones += int'(done);
      end
   endtask

   int hi_c, ri_c, dn_c;

   initial begin
      rst = 1'b0; cfg_wr = 1'b0; cfg_high = '0; cfg_low = '0;
      start = 1'b0; burst_len = '0; stop = 1'b0;
      #10 rst = 1'b1;

      $display("[TB] reset / idle");
      runCycles(3, hi_c, ri_c, dn_c);
      checkOutput("idle_highs", hi_c, 0);
      checkOutput("idle_dones", dn_c, 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_pending", int'(cfg_pending), 0);

      $display("[TB] free-run 3 high / 2 low");
      applyStimulus(1'b1, 8'd2, 8'd1, 1'b0, 8'd0, 1'b0);
      checkOutput("fr_pending_after_wr", int'(cfg_pending), 1);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
      checkOutput("fr_first_rise", int'(rise), 1);
      checkOutput("fr_first_high", int'(clk_out), 1);
      runCycles(10, hi_c, ri_c, dn_c);
      checkOutput("fr_highs_10", hi_c, 6);
      checkOutput("fr_rises_10", ri_c, 2);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      runCycles(6, hi_c, ri_c, dn_c);
      checkOutput("fr_stop_highs", hi_c, 1);
      checkOutput("fr_stop_rises", ri_c, 0);
      checkOutput("fr_stop_dones", dn_c, 1);

      $display("[TB] burst of 4 at period 2");
      applyStimulus(1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd4, 1'b0);
      checkOutput("burst_first_high", int'(clk_out), 1);
      runCycles(10, hi_c, ri_c, dn_c);
      checkOutput("burst_highs_rest", hi_c, 3);
      checkOutput("burst_dones", dn_c, 1);
      checkOutput("burst_busy_end", int'(busy), 0);

      $display("[TB] graceful stop mid-high at 4/4");
      applyStimulus(1'b1, 8'd3, 8'd3, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
      runCycles(1, hi_c, ri_c, dn_c);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      runCycles(8, hi_c, ri_c, dn_c);
      checkOutput("gs_highs", hi_c, 1);
      checkOutput("gs_rises", ri_c, 0);
      checkOutput("gs_dones", dn_c, 1);
      checkOutput("gs_clk_end", int'(clk_out), 0);

      $display("[TB] shadowed reconfig 2/2 -> 5/1");
      applyStimulus(1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
      applyStimulus(1'b1, 8'd4, 8'd0, 1'b0, 8'd0, 1'b0);
      checkOutput("rc_pending_set", int'(cfg_pending), 1);
      runCycles(2, hi_c, ri_c, dn_c);
      checkOutput("rc_old_period_highs", hi_c, 0);
      checkOutput("rc_pending_held", int'(cfg_pending), 1);
      runCycles(1, hi_c, ri_c, dn_c);
      checkOutput("rc_boundary_rise", ri_c, 1);
      checkOutput("rc_pending_clear", int'(cfg_pending), 0);
      runCycles(5, hi_c, ri_c, dn_c);
      checkOutput("rc_new_highs", hi_c, 4);
      checkOutput("rc_new_rises", ri_c, 0);
      runCycles(1, hi_c, ri_c, dn_c);
      checkOutput("rc_next_rise", ri_c, 1);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      runCycles(8, hi_c, ri_c, dn_c);
      checkOutput("rc_stop_dones", dn_c, 1);

      $display("[TB] corner events");
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b1);
      checkOutput("ss_busy", int'(busy), 0);
      checkOutput("ss_clk", int'(clk_out), 0);
      runCycles(2, hi_c, ri_c, dn_c);
      checkOutput("ss_dones", dn_c, 0);

      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0);
      runCycles(5, hi_c, ri_c, dn_c);
      checkOutput("sb_dones", dn_c, 1);
      checkOutput("sb_busy", int'(busy), 0);

      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
      checkOutput("rm_high_before", int'(clk_out), 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("rm_clk_async", int'(clk_out), 0);
      checkOutput("rm_busy_async", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      runCycles(3, hi_c, ri_c, dn_c);
      checkOutput("rm_dones", dn_c, 0);
      checkOutput("rm_highs", hi_c, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
